// File: rtl/legv8_control_unit.sv
// legv8_control_unit: multi-cycle LEGv8 sequencer producing ControlWord/constant for the datapath.
// Latency: FETCH, DECODE, EXECUTE one cycle each; CBZ/CBNZ spend two cycles in EXECUTE.
// Backpressure: none; the datapath consumes one control word every clock, HALT parks until reset.
module legv8_control_unit #(
    parameter int CW_WIDTH        = 34,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [31:0]         IR_out,
    input  logic [3:0]          current_status,
    output logic [CW_WIDTH-1:0] ControlWord,
    output logic [63:0]         constant,
    output logic [1:0]          state,
    output logic                halted
);

    typedef enum logic [1:0] {S_FETCH = 2'b00, S_DECODE = 2'b01, S_EXEC = 2'b10, S_HALT = 2'b11} state_t;

    typedef enum logic [4:0] {
        K_ILL, K_ADD, K_ADDS, K_SUB, K_SUBS, K_AND, K_ORR, K_EOR, K_LSL, K_LSR,
        K_ADDI, K_SUBI, K_ANDI, K_ORRI, K_MOVZ, K_LDUR, K_STUR,
        K_B, K_BL, K_CBZ, K_CBNZ, K_BCOND, K_BR
    } kind_t;

    typedef struct packed {
        logic       addr_sel;
        logic [1:0] dsel;
        logic [1:0] psel;
        logic       pc_sel;
        logic       b_sel;
        logic       il;
        logic       sl;
        logic [4:0] fs;
        logic       c0;
        logic [1:0] size;
        logic       mw;
        logic       rw;
        logic [4:0] da;
        logic [4:0] sa;
        logic [4:0] sb;
    } cw_t;

    localparam cw_t CW_NOP = '{addr_sel: 1'b1, default: '0};

    state_t      r_state;
    logic        r_ex_b;
    state_t      w_state_nxt;
    logic        w_ex_b_nxt;
    kind_t       w_kind;
    cw_t         w_cw;
    logic [63:0] w_const;
    logic        w_cond;
    logic        w_v, w_c, w_n, w_z;
    logic [63:0] w_off26, w_off19, w_imm9, w_movz;

    assign w_v = current_status[3];
    assign w_c = current_status[2];
    assign w_n = current_status[1];
    assign w_z = current_status[0];

    // PC has already advanced by 4 in DECODE, so branch offsets are pre-corrected by -4.
    assign w_off26 = {{36{IR_out[25]}}, IR_out[25:0], 2'b00} - 64'd4;
    assign w_off19 = {{43{IR_out[23]}}, IR_out[23:5], 2'b00} - 64'd4;
    assign w_imm9  = {{55{IR_out[20]}}, IR_out[20:12]};
    assign w_movz  = {48'd0, IR_out[20:5]} << {IR_out[22:21], 4'b0000};

    // Classify the instruction in IR_out; anything unrecognised is K_ILL.
    always_comb begin
        w_kind = K_ILL;
        case (IR_out[31:21])
            11'h458: w_kind = K_ADD;
            11'h558: w_kind = K_ADDS;
            11'h658: w_kind = K_SUB;
            11'h758: w_kind = K_SUBS;
            11'h450: w_kind = K_AND;
            11'h550: w_kind = K_ORR;
            11'h650: w_kind = K_EOR;
            11'h69A: w_kind = K_LSR;
            11'h69B: w_kind = K_LSL;
            11'h6B0: w_kind = K_BR;
            11'h7C2: w_kind = K_LDUR;
            11'h7C0: w_kind = K_STUR;
            default: begin
                if      (IR_out[31:22] == 10'h244) w_kind = K_ADDI;
                else if (IR_out[31:22] == 10'h344) w_kind = K_SUBI;
                else if (IR_out[31:22] == 10'h248) w_kind = K_ANDI;
                else if (IR_out[31:22] == 10'h2C8) w_kind = K_ORRI;
                else if (IR_out[31:23] == 9'h1A5)  w_kind = K_MOVZ;
                else if (IR_out[31:26] == 6'h05)   w_kind = K_B;
                else if (IR_out[31:26] == 6'h25)   w_kind = K_BL;
                else if (IR_out[31:24] == 8'hB4)   w_kind = K_CBZ;
                else if (IR_out[31:24] == 8'hB5)   w_kind = K_CBNZ;
                else if (IR_out[31:24] == 8'h54)   w_kind = K_BCOND;
            end
        endcase
    end

    // Evaluate the B.cond condition code against the registered flags.
    always_comb begin
        w_cond = 1'b0;
        case (IR_out[3:0])
            4'h0: w_cond = w_z;
            4'h1: w_cond = !w_z;
            4'h2: w_cond = w_c;
            4'h3: w_cond = !w_c;
            4'h4: w_cond = w_n;
            4'h5: w_cond = !w_n;
            4'h6: w_cond = w_v;
            4'h7: w_cond = !w_v;
            4'h8: w_cond = w_c && !w_z;
            4'h9: w_cond = !(w_c && !w_z);
            4'hA: w_cond = (w_n == w_v);
            4'hB: w_cond = (w_n != w_v);
            4'hC: w_cond = !w_z && (w_n == w_v);
            4'hD: w_cond = !(!w_z && (w_n == w_v));
            4'hE: w_cond = 1'b1;
            default: w_cond = 1'b0;
        endcase
    end

    // State register; r_ex_b marks the second (branch) half of a CBZ/CBNZ EXECUTE.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_ex_b  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ex_b  <= w_ex_b_nxt;
        end
    end

    // Next state and control word for the current phase; reset forces a NOP word.
    always_comb begin
        w_state_nxt = r_state;
        w_ex_b_nxt  = 1'b0;
        w_cw        = CW_NOP;
        w_const     = '0;
        case (r_state)
            S_FETCH: begin
                w_cw.dsel   = 2'b11;
                w_cw.size   = 2'b10;
                w_cw.il     = 1'b1;
                w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                w_cw.psel   = 2'b01;
                w_state_nxt = (w_kind == K_ILL && HALT_ON_ILLEGAL) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                w_state_nxt = S_FETCH;
                case (w_kind)
                    K_ADD, K_ADDS, K_SUB, K_SUBS, K_AND, K_ORR, K_EOR: begin
                        w_cw.sa = IR_out[9:5];
                        w_cw.sb = IR_out[20:16];
                        w_cw.da = IR_out[4:0];
                        w_cw.rw = 1'b1;
                        w_cw.sl = (w_kind == K_ADDS) || (w_kind == K_SUBS);
                        w_cw.c0 = (w_kind == K_SUB) || (w_kind == K_SUBS);
                        case (w_kind)
                            K_ADD, K_ADDS: w_cw.fs = 5'b01000;
                            K_SUB, K_SUBS: w_cw.fs = 5'b01001;
                            K_ORR:         w_cw.fs = 5'b00100;
                            K_EOR:         w_cw.fs = 5'b01100;
                            default:       w_cw.fs = 5'b00000;
                        endcase
                    end
                    K_LSL, K_LSR, K_ADDI, K_SUBI, K_ANDI, K_ORRI: begin
                        w_cw.sa    = IR_out[9:5];
                        w_cw.da    = IR_out[4:0];
                        w_cw.b_sel = 1'b1;
                        w_cw.rw    = 1'b1;
                        w_cw.c0    = (w_kind == K_SUBI);
                        w_const    = (w_kind == K_LSL || w_kind == K_LSR) ?
                                     {58'd0, IR_out[15:10]} : {52'd0, IR_out[21:10]};
                        case (w_kind)
                            K_LSL:   w_cw.fs = 5'b10100;
                            K_LSR:   w_cw.fs = 5'b10000;
                            K_ADDI:  w_cw.fs = 5'b01000;
                            K_SUBI:  w_cw.fs = 5'b01001;
                            K_ORRI:  w_cw.fs = 5'b00100;
                            default: w_cw.fs = 5'b00000;
                        endcase
                    end
                    K_MOVZ: begin
                        w_cw.fs    = 5'b11100;
                        w_cw.b_sel = 1'b1;
                        w_cw.rw    = 1'b1;
                        w_cw.da    = IR_out[4:0];
                        w_const    = w_movz;
                    end
                    K_LDUR, K_STUR: begin
                        w_cw.addr_sel = 1'b0;
                        w_cw.fs       = 5'b01000;
                        w_cw.b_sel    = 1'b1;
                        w_cw.size     = 2'b11;
                        w_cw.sa       = IR_out[9:5];
                        w_const       = w_imm9;
                        if (w_kind == K_LDUR) begin
                            w_cw.dsel = 2'b11;
                            w_cw.rw   = 1'b1;
                            w_cw.da   = IR_out[4:0];
                        end else begin
                            w_cw.dsel = 2'b01;
                            w_cw.mw   = 1'b1;
                            w_cw.sb   = IR_out[4:0];
                        end
                    end
                    K_B, K_BL: begin
                        w_cw.psel = 2'b10;
                        w_const   = w_off26;
                        if (w_kind == K_BL) begin
                            w_cw.dsel = 2'b10;
                            w_cw.rw   = 1'b1;
                            w_cw.da   = 5'd30;
                        end
                    end
                    K_CBZ, K_CBNZ: begin
                        w_cw.sa = IR_out[4:0];
                        w_cw.sb = 5'd31;
                        if (!r_ex_b) begin
                            w_cw.sl     = 1'b1;
                            w_state_nxt = S_EXEC;
                            w_ex_b_nxt  = 1'b1;
                        end else if (w_z == (w_kind == K_CBZ)) begin
                            w_cw.psel = 2'b10;
                            w_const   = w_off19;
                        end
                    end
                    K_BCOND: begin
                        if (w_cond) begin
                            w_cw.psel = 2'b10;
                            w_const   = w_off19;
                        end
                    end
                    K_BR: begin
                        w_cw.psel   = 2'b11;
                        w_cw.pc_sel = 1'b1;
                        w_cw.sa     = IR_out[9:5];
                    end
                    default: ;
                endcase
            end
            default: w_state_nxt = S_HALT;
        endcase
        if (reset) begin
            w_cw    = CW_NOP;
            w_const = '0;
        end
    end

    assign ControlWord = w_cw;
    assign constant    = w_const;
    assign state       = r_state;
    assign halted      = (r_state == S_HALT) && !reset;

endmodule
